// File: rtl/odo_sbox_bank.sv
// Runtime-loadable S-box lookup bank. A single 2^WIDTH-entry table is loaded
// serially and then serves LANES parallel lookups through a registered
// valid/ready output stage. A seen-bitmap flags tables that are not permutations.
module odo_sbox_bank #(
    parameter int WIDTH = 6,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     ld_valid,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     loading,
    output logic                     table_ready,
    output logic                     perm_err
);

    localparam int              DEPTH = 1 << WIDTH;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    // Table storage is deliberately not reset; a reload is required after reset.
    logic [WIDTH-1:0]       tbl [DEPTH];
    logic [WIDTH-1:0]       addr;
    logic [DEPTH-1:0]       seen;
    logic [LANES*WIDTH-1:0] lookup;
    logic                   ld_we;
    logic                   accept;

    // load_start wins over a coincident ld_valid, so that word is dropped.
    assign ld_we    = loading && ld_valid && !load_start;
    assign in_ready = table_ready && !loading && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Every lane is an independent combinational read of the shared table.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lookup[g*WIDTH +: WIDTH] = tbl[in_data[g*WIDTH +: WIDTH]];
    end

    // Table write port, driven only by accepted load words.
    always_ff @(posedge clk) begin
        if (ld_we) tbl[addr] <= ld_data;
    end

    // Load sequencing and bijectivity tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loading     <= 1'b0;
            table_ready <= 1'b0;
            perm_err    <= 1'b0;
            addr        <= '0;
            seen        <= '0;
        end else if (load_start) begin
            loading     <= 1'b1;
            table_ready <= 1'b0;
            perm_err    <= 1'b0;
            addr        <= '0;
            seen        <= '0;
        end else if (ld_we) begin
            addr          <= addr + 1'b1;
            seen[ld_data] <= 1'b1;
            if (seen[ld_data]) perm_err <= 1'b1;
            if (addr == LAST) begin
                loading     <= 1'b0;
                table_ready <= 1'b1;
            end
        end
    end

    // Registered output stage: capture on accept, drop when consumed, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_odo_sbox_bank.sv
// Bench for odo_sbox_bank: a table/duplicate reference model feeds a scoreboard
// queue at request issue; an independent monitor pops on every output handshake.
module tb_odo_sbox_bank;

    localparam int W = 6;
    localparam int L = 4;
    localparam int N = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load_start = 1'b0;
    logic           ld_valid = 1'b0;
    logic [W-1:0]   ld_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [L*W-1:0] out_data;
    logic           loading;
    logic           table_ready;
    logic           perm_err;

    odo_sbox_bank #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .loading(loading), .table_ready(table_ready), .perm_err(perm_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rand_rdy = 1'b0;

    logic [W-1:0]   ref_tbl [N];
    logic [W-1:0]   words   [N];
    logic [L*W-1:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [L*W-1:0] exp_of(input logic [L*W-1:0] d);
        logic [L*W-1:0] e;
        for (int l = 0; l < L; l++) e[l*W +: W] = ref_tbl[d[l*W +: W]];
        return e;
    endfunction

    // Issue one lookup (called at posedge+1); expected result queued on acceptance.
    task automatic lookup(input logic [L*W-1:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_of(d));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("lookup_timeout", 0, 1);
    endtask

    // Load n words from words[] after a load_start; collide drives a word with load_start.
    task automatic do_load(input int n, input bit collide);
        bit seen_m [N];
        bit dup = 1'b0;
        bit last;
        for (int v = 0; v < N; v++) seen_m[v] = 1'b0;
        @(posedge clk); #1;
        load_start = 1'b1;
        ld_valid   = collide;
        ld_data    = 6'h2a;
        @(posedge clk); #1;
        load_start = 1'b0;
        ld_valid   = 1'b0;
        chk("start_loading", loading, 1);
        chk("start_table_ready", table_ready, 0);
        chk("start_perm_err", perm_err, 0);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            @(posedge clk); #1;
            ld_valid = 1'b0;
            ref_tbl[i] = words[i];
            if (seen_m[words[i]]) dup = 1'b1;
            seen_m[words[i]] = 1'b1;
            last = (i == N - 1);
            chk("load_perm_err", perm_err, dup);
            chk("load_table_ready", table_ready, last);
            chk("load_loading", loading, !last);
            if (!last) chk("load_in_ready", in_ready, 0);
        end
    endtask

    // Scoreboard monitor, plus stability of a stalled result.
    initial begin
        bit             held = 1'b0;
        logic [L*W-1:0] held_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, held_data);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_output", 1, 0);
                    else chk("scoreboard", out_data, sb.pop_front());
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int             c0;
        logic [L*W-1:0] d;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_loading", loading, 0);
        chk("rst_table_ready", table_ready, 0);
        chk("rst_perm_err", perm_err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 0);

        // Affine permutation table; in_ready rises with table_ready
        for (int i = 0; i < N; i++) words[i] = W'((5 * i + 3) % N);
        do_load(N, 1'b0);
        chk("first_in_ready", in_ready, 1);
        chk("first_perm_err", perm_err, 0);

        lookup({6'd32, 6'd63, 6'd1, 6'd0});
        chk("known_valid", out_valid, 1);
        chk("known_data", out_data, {6'd35, 6'd62, 6'd8, 6'd3});

        // Back-to-back stream, one transfer per cycle
        c0 = cyc;
        for (int i = 0; i < N; i++) lookup(L*W'($urandom));
        chk("stream_cycles", cyc - c0, N);

        // Stall for 3 cycles with a request waiting
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = L*W'($urandom);
        d         = in_data;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        lookup(d);

        // Duplicate table: i^1 with entry 10 forced to 0
        for (int i = 0; i < N; i++) words[i] = W'(i ^ 1);
        words[10] = '0;
        do_load(N, 1'b0);
        chk("dup_perm_err", perm_err, 1);
        for (int i = 0; i < 8; i++) lookup(L*W'($urandom));

        // Pending result across a restarted load
        for (int i = 0; i < N; i++) words[i] = W'((5 * i + 3) % N);
        lookup(L*W'($urandom));
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) words[i] = W'((7 * i + 1) % N);
        do_load(20, 1'b0);
        for (int i = 0; i < N; i++) words[i] = W'((9 * i + 5) % N);
        do_load(N, 1'b0);
        chk("pending_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) lookup(L*W'($urandom));

        // Asynchronous reset mid-load, then ld_valid without load_start
        do_load(40, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_loading", loading, 0);
        chk("arst_table_ready", table_ready, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = 6'd5;
            @(posedge clk); #1;
            chk("stray_loading", loading, 0);
            chk("stray_table_ready", table_ready, 0);
            chk("stray_perm_err", perm_err, 0);
        end
        ld_valid = 1'b0;

        // load_start with ld_valid: word dropped, next word lands at address 0
        for (int i = 0; i < N; i++) words[i] = W'((11 * i + 7) % N);
        do_load(N, 1'b1);
        lookup('0);
        for (int i = 0; i < 4; i++) lookup(L*W'($urandom));

        // Random traffic under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) lookup(L*W'($urandom));
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/odo_sbox_bank.md
# odo_sbox_bank

Runtime-loadable, multi-lane S-box lookup engine for the Odo hashing core. It replaces the fixed 6-bit single-lane ROM S-boxes with one table of 2^WIDTH entries that is loaded serially at each epoch change. LANES parallel lookups share the table behind a registered valid/ready output stage. A bijectivity checker flags any loaded table that is not a permutation.

## Interface
- WIDTH, 6, S-box input/output width in bits (4..8); the table has 2^WIDTH entries
- LANES, 4, number of parallel lookups per transfer (1..16)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse: begin a new table load at address 0
- ld_valid  in  1  table word valid; ignored unless loading
- ld_data  in  WIDTH  table word for the current load address
- in_valid  in  1  lookup request valid
- in_ready  out  1  lookup request accepted when in_valid && in_ready
- in_data  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  1  lookup result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  LANES*WIDTH  lane i result = table[in lane i]
- loading  out  1  load in progress
- table_ready  out  1  a complete table is loaded
- perm_err  out  1  sticky: the last or current load wrote a duplicate value

## Operation
- Reset values: loading=0, table_ready=0, perm_err=0, out_valid=0, out_data=0, load address=0, seen bitmap cleared. Table contents are not reset. in_ready=0 until the first load completes.
- Load:
  - load_start sets loading=1 and table_ready=0, zeroes the address, and clears the seen bitmap and perm_err. This applies in any state, including mid-load, which restarts the load.
  - Each ld_valid cycle while loading=1 writes table[addr]=ld_data and increments addr.
  - The word at addr = 2^WIDTH-1 ends the load: loading=0 and table_ready=1 from the next cycle.
- Bijectivity check: each write tests seen[ld_data]. If it is already set, perm_err goes to 1 and stays set until the next load_start. Otherwise seen[ld_data] is set. A table with perm_err=1 still becomes table_ready; the consumer decides whether to use it.
- load_start and ld_valid in the same cycle: load_start wins and the word is dropped.
- Lookup:
  - in_ready = table_ready && !loading && (!out_valid || out_ready).
  - On accept, every lane's result is registered into out_data and out_valid=1.
  - out_valid clears when out_ready=1 and no new request is accepted.
  - While out_valid && !out_ready, out_data holds stable.
- Load versus pending result: an out_data already valid when load_start arrives remains valid with old-table values until consumed. No new request is accepted until the load completes.
- All lanes are independent reads of the same table. Identical lane inputs are legal.

## Timing
- Lookup latency is 1 cycle. A request accepted at edge k gives out_valid=1 and out_data during cycle k+1.
- Throughput is one LANES-wide transfer per cycle when out_ready is held at 1.
- A load takes exactly 2^WIDTH ld_valid cycles. Gaps in ld_valid are allowed.
- table_ready rises the cycle after the final word is written. in_ready can assert in that same cycle.
- perm_err rises the cycle after the offending write.
- Asserting rst_n low mid-load or mid-transfer immediately forces the reset values. The table must be reloaded.

## Test plan
- Reset, then load table[i]=(5*i+3) mod 64 with WIDTH=6 and LANES=4. Look up lanes {0,1,63,32} -> out_data lanes {3,8,62,35} one cycle later; perm_err=0.
- Stream 64 back-to-back requests with out_ready=1 -> one result per cycle, in order, with no bubbles. Hold out_ready=0 for 3 cycles -> out_data is stable, in_ready=0, and nothing is lost.
- Load table[i]=i^1 except table[10]=0 -> perm_err=1 from the cycle after address 10 is written, table_ready=1 at the end. A following valid load clears perm_err at load_start.
- Issue load_start at address 20, then a full new load -> table_ready stays 0 until the 64th new word. Lookups then return the new table; a result pending before load_start returns the old-table value.
- Assert rst_n low at load address 40 -> loading=0, table_ready=0, in_ready=0. Check that ld_valid without load_start writes nothing.
- Issue load_start and ld_valid together -> the word is dropped and the first stored word is the next ld_valid.
